// File: rtl/grid_pkg.sv
// Shared grid definitions: sizes, game-state code, cell encoding, commit FSM states.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package grid_pkg;

  localparam int GRID_N = 5;
  localparam int CELLS  = GRID_N * GRID_N;

  localparam logic [2:0] GAME_PLAY = 3'b000;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITE,
    DONE,
    REJECT
  } commit_st_t;

  // Row-major flat cell index; row/col are always < GRID_N so 5 bits never overflow.
  function automatic logic [4:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return (5'(row) * 5'd5) + 5'(col);
  endfunction

endpackage

// File: rtl/place_commit_rise_detect.sv
// Two-flop rising-edge detector for an already-synchronized button level.
// Latency: o_rise is high the cycle after the level is first sampled high.
// Backpressure: none; samples every cycle, a held level yields a single rise.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_q;
  logic r_qq;

  // Delay line of the level; the pair differs for exactly one cycle per edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q  <= 1'b0;
      r_qq <= 1'b0;
    end else begin
      r_q  <= i_level;
      r_qq <= r_q;
    end
  end

  assign o_rise = r_q & ~r_qq;

endmodule

// File: rtl/place_commit.sv
// Cursor register, board owner and placement commit FSM for the 5x5 grid.
// Latency: rise -> place_ok 3 cycles (via WRITE/DONE), rise -> place_reject 2 cycles.
// Backpressure: none; rises arriving while a commit is in flight are dropped.
module place_commit
  import grid_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         state,
  input  logic [2:0]         select_row,
  input  logic [2:0]         select_col,
  input  logic               confirm,
  output logic [2:0]         current_row,
  output logic [2:0]         current_col,
  output logic [2*CELLS-1:0] board,
  output logic               player,
  output logic               place_ok,
  output logic               place_reject,
  output logic [4:0]         placed_count,
  output logic               board_full
);

  logic [2:0]         r_row;
  logic [2:0]         r_col;
  logic [2*CELLS-1:0] r_board;
  logic               r_player;
  logic [4:0]         r_count;
  logic [4:0]         r_idx;
  commit_st_t         r_st;
  commit_st_t         w_st_nxt;
  logic               w_rise;
  logic               w_play;
  logic               w_sel_ok;
  logic               w_full;
  logic [1:0]         w_cell;
  logic               w_place_ok;
  logic               w_place_rej;

  rise_detect u_confirm_rise (
    .clock   (clock),
    .reset   (reset),
    .i_level (confirm),
    .o_rise  (w_rise)
  );

  assign w_play   = (state == GAME_PLAY);
  assign w_sel_ok = (select_row < 3'(GRID_N)) && (select_col < 3'(GRID_N));
  assign w_full   = (r_count == 5'(CELLS));
  assign w_cell   = r_board[{r_idx, 1'b0} +: 2];

  // Commit FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_st <= IDLE;
    else       r_st <= w_st_nxt;
  end

  // Next-state and one-cycle result pulses.
  always_comb begin
    w_st_nxt    = r_st;
    w_place_ok  = 1'b0;
    w_place_rej = 1'b0;
    case (r_st)
      IDLE:    if (w_rise && w_play) w_st_nxt = CHECK;
      CHECK:   w_st_nxt = (w_full || (w_cell != EMPTY)) ? REJECT : WRITE;
      WRITE:   w_st_nxt = DONE;
      DONE:    begin w_place_ok  = 1'b1; w_st_nxt = IDLE; end
      REJECT:  begin w_place_rej = 1'b1; w_st_nxt = IDLE; end
      default: w_st_nxt = IDLE;
    endcase
  end

  // Cursor follows in-range selections only while idle in PLAY; frozen otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_play && (r_st == IDLE) && w_sel_ok) begin
      r_row <= select_row;
      r_col <= select_col;
    end
  end

  // Snapshot the target cell when a transaction starts so cursor moves cannot retarget it.
  always_ff @(posedge clock) begin
    if (reset)                                 r_idx <= '0;
    else if ((r_st == IDLE) && w_rise && w_play) r_idx <= cell_index(r_row, r_col);
  end

  // Board write and occupancy count; CHECK already refused full boards, the guard is belt and braces.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_board <= '0;
      r_count <= '0;
    end else if (r_st == WRITE) begin
      r_board[{r_idx, 1'b0} +: 2] <= r_player ? P2 : P1;
      if (!w_full) r_count <= r_count + 5'd1;
    end
  end

  // Turn passes only after a successful placement.
  always_ff @(posedge clock) begin
    if (reset)              r_player <= 1'b0;
    else if (r_st == DONE)  r_player <= ~r_player;
  end

  assign current_row  = r_row;
  assign current_col  = r_col;
  assign board        = r_board;
  assign player       = r_player;
  assign place_ok     = w_place_ok;
  assign place_reject = w_place_rej;
  assign placed_count = r_count;
  assign board_full   = w_full;

endmodule

// File: tb/tb_place_commit.sv
// Self-checking bench for place_commit against a cell-array reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_place_commit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  state = 3'b000;
  logic [2:0]  select_row = 3'd0;
  logic [2:0]  select_col = 3'd0;
  logic        confirm = 1'b0;
  logic [2:0]  current_row;
  logic [2:0]  current_col;
  logic [49:0] board;
  logic        player;
  logic        place_ok;
  logic        place_reject;
  logic [4:0]  placed_count;
  logic        board_full;

  place_commit dut (
    .clock        (clock),
    .reset        (reset),
    .state        (state),
    .select_row   (select_row),
    .select_col   (select_col),
    .confirm      (confirm),
    .current_row  (current_row),
    .current_col  (current_col),
    .board        (board),
    .player       (player),
    .place_ok     (place_ok),
    .place_reject (place_reject),
    .placed_count (placed_count),
    .board_full   (board_full)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: game rules on a plain array.
  int m_cell[25];
  int m_player;
  int m_count;
  int m_row;
  int m_col;

  function automatic logic [49:0] model_board();
    logic [49:0] b;
    b = '0;
    for (int i = 0; i < 25; i++) b[2*i +: 2] = 2'(m_cell[i]);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 25; i++) m_cell[i] = 0;
    m_player = 0; m_count = 0; m_row = 0; m_col = 0;
  endtask

  // Predicts the outcome of a press at the model cursor and applies it.
  task automatic model_press(output bit exp_ok);
    int idx;
    idx = 5 * m_row + m_col;
    if (m_count == 25 || m_cell[idx] != 0) exp_ok = 1'b0;
    else begin
      m_cell[idx] = (m_player == 1) ? 2 : 1;
      m_count++;
      m_player = 1 - m_player;
      exp_ok = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cursor(input int r, input int c);
    select_row = 3'(r);
    select_col = 3'(c);
    tick();
    if (r < 5 && c < 5) begin m_row = r; m_col = c; end
  endtask

  // Holds confirm for 10 cycles and records pulses with their cycle offset from the press.
  task automatic press(output int n_ok, output int n_rej, output int ok_at, output int rej_at, output int n_both);
    n_ok = 0; n_rej = 0; ok_at = -1; rej_at = -1; n_both = 0;
    confirm = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (place_ok) begin n_ok++; ok_at = t; end
      if (place_reject) begin n_rej++; rej_at = t; end
      if (place_ok && place_reject) n_both++;
    end
    confirm = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    confirm = 1'b0;
    state = 3'b000;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    model_reset();
    n_cmp++;
    if ({current_row, current_col} !== 6'd0) begin n_err++; $display("FAIL reset_cursor: got %0d,%0d want 0,0", current_row, current_col); end
    n_cmp++;
    if (board !== 50'd0) begin n_err++; $display("FAIL reset_board: got %h want 0", board); end
    n_cmp++;
    if ({player, place_ok, place_reject, board_full} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {player, place_ok, place_reject, board_full}); end
    n_cmp++;
    if (placed_count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", placed_count); end
    reset = 1'b0;
  endtask

  task automatic test_cursor();
    set_cursor(2, 3);
    n_cmp++;
    if (current_row !== 3'd2 || current_col !== 3'd3) begin n_err++; $display("FAIL cursor_capture: got %0d,%0d want 2,3", current_row, current_col); end
    n_cmp++;
    if (board !== 50'd0 || player !== 1'b0) begin n_err++; $display("FAIL cursor_side_effect: board %h player %0d want 0 0", board, player); end
  endtask

  task automatic test_place();
    int n_ok, n_rej, ok_at, rej_at, n_both;
    bit exp_ok;
    model_press(exp_ok);
    press(n_ok, n_rej, ok_at, rej_at, n_both);
    n_cmp++;
    if (n_ok !== 1 || ok_at !== 4 || n_rej !== 0) begin n_err++; $display("FAIL place_pulse: ok %0d at %0d rej %0d, want ok 1 at 4 rej 0", n_ok, ok_at, n_rej); end
    n_cmp++;
    if (board[27:26] !== 2'b01) begin n_err++; $display("FAIL place_cell: got %b want 01", board[27:26]); end
    n_cmp++;
    if (board !== model_board()) begin n_err++; $display("FAIL place_board: got %h want %h", board, model_board()); end
    n_cmp++;
    if (player !== 1'b1 || placed_count !== 5'd1) begin n_err++; $display("FAIL place_turn: player %0d count %0d want 1 1", player, placed_count); end
  endtask

  task automatic test_reject();
    int n_ok, n_rej, ok_at, rej_at, n_both;
    bit exp_ok;
    model_press(exp_ok);
    press(n_ok, n_rej, ok_at, rej_at, n_both);
    n_cmp++;
    if (n_rej !== 1 || rej_at !== 3 || n_ok !== 0) begin n_err++; $display("FAIL reject_pulse: rej %0d at %0d ok %0d, want rej 1 at 3 ok 0", n_rej, rej_at, n_ok); end
    n_cmp++;
    if (board !== model_board() || player !== 1'b1 || placed_count !== 5'd1) begin n_err++; $display("FAIL reject_state: board %h player %0d count %0d want %h 1 1", board, player, placed_count, model_board()); end
  endtask

  task automatic test_cursor_hold();
    set_cursor(5, 1);
    n_cmp++;
    if (current_row !== 3'd2 || current_col !== 3'd3) begin n_err++; $display("FAIL hold_row5: got %0d,%0d want 2,3", current_row, current_col); end
    set_cursor(1, 7);
    n_cmp++;
    if (current_row !== 3'd2 || current_col !== 3'd3) begin n_err++; $display("FAIL hold_col7: got %0d,%0d want 2,3", current_row, current_col); end
    set_cursor(4, 0);
    n_cmp++;
    if (current_row !== 3'd4 || current_col !== 3'd0) begin n_err++; $display("FAIL cursor_edge: got %0d,%0d want 4,0", current_row, current_col); end
  endtask

  task automatic test_not_play();
    int n_ok, n_rej, ok_at, rej_at, n_both, pulses;
    state = 3'b001;
    select_row = 3'd1;
    select_col = 3'd1;
    press(n_ok, n_rej, ok_at, rej_at, n_both);
    n_cmp++;
    if (n_ok + n_rej !== 0 || board !== model_board()) begin n_err++; $display("FAIL notplay_press: pulses %0d board %h want 0 %h", n_ok + n_rej, board, model_board()); end
    n_cmp++;
    if (current_row !== 3'(m_row) || current_col !== 3'(m_col)) begin n_err++; $display("FAIL notplay_frozen: got %0d,%0d want %0d,%0d", current_row, current_col, m_row, m_col); end
    select_row = 3'(m_row);
    select_col = 3'(m_col);
    pulses = 0;
    confirm = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    state = 3'b000;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (place_ok || place_reject) pulses++;
    end
    confirm = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (pulses !== 0 || board !== model_board() || placed_count !== 5'(m_count)) begin n_err++; $display("FAIL held_across_play: pulses %0d count %0d want 0 %0d", pulses, placed_count, m_count); end
  endtask

  task automatic test_fill();
    int perm[25];
    int n_ok, n_rej, ok_at, rej_at, n_both, j, tmp;
    bit exp_ok;
    do_reset();
    for (int i = 0; i < 25; i++) perm[i] = i;
    for (int i = 24; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int k = 0; k < 25; k++) begin
      set_cursor(perm[k] / 5, perm[k] % 5);
      model_press(exp_ok);
      press(n_ok, n_rej, ok_at, rej_at, n_both);
      n_cmp++;
      if (n_ok !== 1 || ok_at !== 4 || n_rej !== 0) begin n_err++; $display("FAIL fill_pulse[%0d]: ok %0d at %0d rej %0d want 1 at 4 rej 0", k, n_ok, ok_at, n_rej); end
      n_cmp++;
      if (board !== model_board() || board_full !== (m_count == 25)) begin n_err++; $display("FAIL fill_board[%0d]: board %h full %0d want %h %0d", k, board, board_full, model_board(), m_count == 25); end
    end
    n_cmp++;
    if (placed_count !== 5'd25 || board_full !== 1'b1 || player !== 1'b1) begin n_err++; $display("FAIL fill_full: count %0d full %0d player %0d want 25 1 1", placed_count, board_full, player); end
    set_cursor(perm[7] / 5, perm[7] % 5);
    model_press(exp_ok);
    press(n_ok, n_rej, ok_at, rej_at, n_both);
    n_cmp++;
    if (n_rej !== 1 || rej_at !== 3 || n_ok !== 0 || placed_count !== 5'd25) begin n_err++; $display("FAIL fill_26th: rej %0d at %0d ok %0d count %0d want 1 3 0 25", n_rej, rej_at, n_ok, placed_count); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    set_cursor(3, 1);
    confirm = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    confirm = 1'b0;
    tick();
    n_cmp++;
    if (board !== 50'd0 || placed_count !== 5'd0 || place_ok !== 1'b0 || player !== 1'b0) begin n_err++; $display("FAIL reset_mid_write: board %h count %0d ok %0d player %0d want 0 0 0 0", board, placed_count, place_ok, player); end
    reset = 1'b0;
    model_reset();
    pulses = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (place_ok || place_reject) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || board !== 50'd0) begin n_err++; $display("FAIL reset_mid_after: pulses %0d board %h want 0 0", pulses, board); end
  endtask

  task automatic test_random();
    int n_ok, n_rej, ok_at, rej_at, n_both;
    bit exp_ok;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      set_cursor($urandom_range(6, 0), $urandom_range(6, 0));
      n_cmp++;
      if (current_row !== 3'(m_row) || current_col !== 3'(m_col)) begin n_err++; $display("FAIL rand_cursor[%0d]: got %0d,%0d want %0d,%0d", k, current_row, current_col, m_row, m_col); end
      if ($urandom_range(1, 0) == 1) begin
        model_press(exp_ok);
        press(n_ok, n_rej, ok_at, rej_at, n_both);
        n_cmp++;
        if (n_both !== 0 || (exp_ok && (n_ok !== 1 || ok_at !== 4 || n_rej !== 0)) || (!exp_ok && (n_rej !== 1 || rej_at !== 3 || n_ok !== 0))) begin
          n_err++; $display("FAIL rand_outcome[%0d]: ok %0d@%0d rej %0d@%0d want ok=%0d", k, n_ok, ok_at, n_rej, rej_at, exp_ok);
        end
        n_cmp++;
        if (board !== model_board() || player !== 1'(m_player) || placed_count !== 5'(m_count)) begin
          n_err++; $display("FAIL rand_state[%0d]: board %h player %0d count %0d want %h %0d %0d", k, board, player, placed_count, model_board(), m_player, m_count);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cursor();
    test_place();
    test_reject();
    test_cursor_hold();
    test_not_play();
    test_fill();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/place_commit.md
Name: place_commit

Overview:
- Consumer end of the cursor path on the 5x5 game grid.
- Registers the selected row/column from the cursor-move logic into the current cursor position, and feeds that position back to the cursor-move logic.
- On a confirm press, checks the addressed board cell, writes the current player's mark if the cell is empty, and toggles the turn.
- Owns the board state that the display and win-check logic read.

Parameters:
- GRID_N, 5, grid side length; indices 0..GRID_N-1.
- CELLS, 25, GRID_N*GRID_N; derived, not overridden.

Ports:
- clock  in  1  system clock
- reset  in  1  reset
- state  in  3  game state; block is active only when state == 3'b000 (PLAY)
- select_row  in  3  requested cursor row from the cursor-move logic
- select_col  in  3  requested cursor column from the cursor-move logic
- confirm  in  1  confirm button level, already synchronized upstream
- current_row  out  3  registered cursor row, returned to the cursor-move logic
- current_col  out  3  registered cursor column, returned to the cursor-move logic
- board  out  50  cell (r,c) occupies bits [2*(5r+c)+1 : 2*(5r+c)]
- player  out  1  side to move; 0 = P1, 1 = P2
- place_ok  out  1  one-cycle pulse when a mark has been written
- place_reject  out  1  one-cycle pulse when a placement is refused
- placed_count  out  5  number of occupied cells, 0..25
- board_full  out  1  high when placed_count == 25

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clock.
- Reset: all outputs are 0; every board cell is EMPTY (2'b00); FSM goes to IDLE; edge-detect flops are cleared.
- Cursor capture:
  - Condition: state == PLAY and FSM in IDLE.
  - If select_row < 5 and select_col < 5, current_row/col take select_row/col on the next clock.
  - Otherwise current_row/col hold.
  - The cursor is frozen outside IDLE and outside PLAY.
- Confirm edge detect:
  - Two flops, confirm_q and confirm_qq, sample every cycle regardless of state.
  - rise = confirm_q & ~confirm_qq.
  - A held button produces exactly one rise.
- FSM, states IDLE, CHECK, WRITE, DONE, REJECT:
  - IDLE: on rise while state == PLAY, latch idx = 5*current_row + current_col (5-bit, no overflow), then go to CHECK. A rise outside PLAY is dropped.
  - CHECK: if board_full, or cell[idx] != EMPTY, go to REJECT; else go to WRITE.
  - WRITE: cell[idx] <= player ? 2'b10 : 2'b01; placed_count += 1; go to DONE.
  - DONE: place_ok = 1 for this cycle; player toggles; go to IDLE.
  - REJECT: place_reject = 1 for this cycle; player is unchanged; go to IDLE.
- Latency: rise visible in cycle N -> place_ok or place_reject asserted in cycle N+3 (DONE) or N+2 (REJECT).
- Rises arriving while the FSM is outside IDLE are dropped, not queued.
- Leaving PLAY mid-transaction: an in-flight CHECK/WRITE/DONE/REJECT completes atomically; no new transaction starts until state returns to PLAY.
- Reset mid-transaction: reset wins in the same cycle; no partial write, no pulse.
- placed_count saturates at 25; the REJECT path guarantees it never increments past 25.
- place_ok and place_reject are never high in the same cycle.

Decomposition:
- Package grid_pkg holds:
  - GRID_N and CELLS
  - GAME_PLAY = 3'b000
  - typedef cell_t enum {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10}
  - typedef commit_st_t for the FSM states
  - a function cell_index(row, col) returning 5*row + col
- One sub-module, rise_detect: the two-flop rising-edge detector with synchronous reset, reused by the confirm path.

Test Plan:
- Reset, then select (2,3) in PLAY for 1 cycle -> current_row=2, current_col=3 on the next cycle; board all zero; player=0.
- Cursor at (2,3), confirm 0->1 held for 10 cycles -> exactly one place_ok at N+3; board bits[27:26]=01; player=1; placed_count=1.
- Confirm again at (2,3) -> place_reject at N+2; board unchanged; player stays 1; count stays 1.
- select_row=5 or select_col=7 -> current_row/col hold their previous values.
- state=3'b001, confirm pulse -> no pulse, no write; a second confirm held across the switch to PLAY must not produce a spurious placement.
- Fill all 25 cells with alternating confirms -> board_full=1 and placed_count=25 after the 25th place_ok; a 26th confirm gives place_reject.
- Assert reset during WRITE -> next cycle board all zero, count 0, no place_ok.
